// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 8N1-style UART receiver with a two-flop input synchronizer,
// mid-bit sampling, a framing-error report and a BREAK hold state.
// Optional feature macro: UART_RX_PARITY_EN adds one even-parity bit between
// the data bits and the stop bit, plus a parity_err output pulse.
//
// Output handshake: rx_valid is a single-cycle strobe with no back-pressure.
// data_bits_rx is valid in the rx_valid cycle and holds until the next
// rx_valid. frame_err (and parity_err when built) are single-cycle strobes
// that never coincide with rx_valid. There is no ready input; a consumer
// must capture the word in the rx_valid cycle.
module uart_rx #(
  parameter int WORD_SIZE   = 8,
  parameter int PULSE_WIDTH = 434
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  output logic [WORD_SIZE-1:0] data_bits_rx,
  output logic                 rx_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 rx_busy
);

  // Cycle counter runs 0..PULSE_WIDTH-1 within one bit period.
  localparam int CW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  // Bit counter counts data samples 0..WORD_SIZE-1.
  localparam int BW = $clog2(WORD_SIZE + 1);

  localparam logic [CW-1:0] C_HALF     = CW'(PULSE_WIDTH / 2 - 1);
  localparam logic [CW-1:0] C_LAST     = CW'(PULSE_WIDTH - 1);
  localparam logic [BW-1:0] C_BIT_LAST = BW'(WORD_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t                 r_state;
  logic                   r_sync1;
  logic                   r_sync2;
  logic [CW-1:0]          r_cnt;
  logic [BW-1:0]          r_bit_cnt;
  logic [WORD_SIZE-1:0]   r_shift;
  logic [WORD_SIZE-1:0]   r_data;
  logic                   r_valid;
  logic                   r_ferr;
  // Stop bit was good; the word is published on the following cycle.
  logic                   r_done;
`ifdef UART_RX_PARITY_EN
  logic                   r_par_ok;
  logic                   r_perr;
`endif

  logic                   w_rx_s;
  logic [WORD_SIZE-1:0]   w_shift_next;

  assign w_rx_s = r_sync2;

  // Two-flop synchronizer; resets to the idle (high) line level so that a
  // reset never looks like a start bit by itself.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // New bits enter at the MSB end so the first received bit ends up in the LSB.
  generate
    if (WORD_SIZE > 1) begin : g_shift_wide
      assign w_shift_next = {w_rx_s, r_shift[WORD_SIZE-1:1]};
    end else begin : g_shift_one
      assign w_shift_next = w_rx_s;
    end
  endgenerate

  // Receive FSM: start detection, mid-bit sampling, stop/break handling and
  // the registered output strobes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_done    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_ok  <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_done  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif

      // Publish one cycle after the good stop sample; the FSM is already back
      // in IDLE so a start bit in this cycle is not missed.
      if (r_done) begin
`ifdef UART_RX_PARITY_EN
        if (r_par_ok) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_perr  <= 1'b1;
        end
`else
        r_data  <= r_shift;
        r_valid <= 1'b1;
`endif
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state   <= S_START;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
          end
        end

        S_START: begin
          if (r_cnt == C_HALF) begin
            r_cnt <= '0;
            // A line that is high again at mid-start was only a glitch.
            if (w_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_cnt == C_LAST) begin
            r_cnt   <= '0;
            r_shift <= w_shift_next;
            if (r_bit_cnt == C_BIT_LAST) begin
              r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              r_state   <= S_PARITY;
`else
              r_state   <= S_STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_cnt == C_LAST) begin
            r_cnt    <= '0;
            // Even parity: data ones plus the parity bit must be even.
            r_par_ok <= ((^r_shift) == w_rx_s);
            r_state  <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (r_cnt == C_LAST) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_BREAK: begin
          // Wait out a held-low line so it reports only one framing error.
          if (w_rx_s) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign data_bits_rx = r_data;
  assign rx_valid     = r_valid;
  assign frame_err    = r_ferr;
  assign rx_busy      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err   = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx: directed bench for uart_rx at WORD_SIZE=8, PULSE_WIDTH=16.
module tb_uart_rx;

  localparam int WS = 8;
  localparam int PW = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 3 + PW / 2 + (WS + 1) * PW + PW;
`else
  localparam int LAT = 3 + PW / 2 + (WS + 1) * PW;
`endif

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rstn;
  logic          rx;
  logic [WS-1:0] data_bits_rx;
  logic          rx_valid;
  logic          frame_err;
  logic          rx_busy;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_rx #(.WORD_SIZE(WS), .PULSE_WIDTH(PW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .rx           (rx),
    .data_bits_rx (data_bits_rx),
    .rx_valid     (rx_valid),
    .frame_err    (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err   (parity_err),
`endif
    .rx_busy      (rx_busy)
  );

  // ---------------- scoreboard state ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int valid_cnt    = 0;
  int ferr_cnt     = 0;
  int perr_cnt     = 0;
  int both_cnt     = 0;
  int last_valid_cyc = 0;
  int frame_start_cyc = 0;
  logic [WS-1:0] exp_q[$];
  logic [WS-1:0] obs_q[$];

  always @(posedge clk) cyc = cyc + 1;

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      obs_q.push_back(data_bits_rx);
      valid_cnt = valid_cnt + 1;
      last_valid_cyc = cyc;
    end
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    if (rx_valid && frame_err) both_cnt = both_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt = perr_cnt + 1;
    if (parity_err && rx_valid) both_cnt = both_cnt + 1;
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(PW);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    tick(n);
  endtask

  task automatic send_frame(input logic [WS-1:0] d, input logic stop_b);
    frame_start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < WS; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_b);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [WS-1:0] d, input logic p);
    frame_start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < WS; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(1'b1);
  endtask
`endif

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    rx   = 1'b1;
    tick(3);
    tests_run++;
    if (data_bits_rx !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_data got=%h exp=%h", data_bits_rx, 8'h00);
    end
    tests_run++;
    if (rx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid got=%b exp=0", rx_valid);
    end
    tests_run++;
    if (frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ferr got=%b exp=0", frame_err);
    end
    tests_run++;
    if (rx_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy got=%b exp=0", rx_busy);
    end
    rstn = 1'b1;
    idle(5);
    tests_run++;
    if (rx_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_busy got=%b exp=0", rx_busy);
    end
  endtask

  task automatic test_single();
    int v0;
    v0 = valid_cnt;
    send_frame(8'hAB, 1'b1);
    idle(4);
    tests_run++;
    if (valid_cnt - v0 !== 1) begin
      tests_failed++;
      $display("FAIL single_pulses got=%0d exp=1", valid_cnt - v0);
    end
    tests_run++;
    if (last_valid_cyc - frame_start_cyc !== LAT + 1) begin
      tests_failed++;
      $display("FAIL single_latency got=%0d exp=%0d", last_valid_cyc - frame_start_cyc - 1, LAT);
    end
    tests_run++;
    if (data_bits_rx !== 8'hAB) begin
      tests_failed++;
      $display("FAIL single_data got=%h exp=ab", data_bits_rx);
    end
    tests_run++;
    if (rx_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_busy got=%b exp=0", rx_busy);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    logic [WS-1:0] e;
    logic [WS-1:0] o;
    v0 = valid_cnt;
    obs_q.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    tests_run++;
    if (valid_cnt - v0 !== 2) begin
      tests_failed++;
      $display("FAIL b2b_pulses got=%0d exp=2", valid_cnt - v0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin
        tests_failed++;
        $display("FAIL b2b_data got=none exp=%h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          tests_failed++;
          $display("FAIL b2b_data got=%h exp=%h", o, e);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int v0;
    int f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    tick(5);
    idle(30);
    tests_run++;
    if (valid_cnt - v0 !== 0) begin
      tests_failed++;
      $display("FAIL glitch_valid got=%0d exp=0", valid_cnt - v0);
    end
    tests_run++;
    if (ferr_cnt - f0 !== 0) begin
      tests_failed++;
      $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt - f0);
    end
    tests_run++;
    if (rx_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_busy got=%b exp=0", rx_busy);
    end
    send_frame(8'h55, 1'b1);
    idle(4);
    tests_run++;
    if (valid_cnt - v0 !== 1) begin
      tests_failed++;
      $display("FAIL glitch_next_pulses got=%0d exp=1", valid_cnt - v0);
    end
    tests_run++;
    if (data_bits_rx !== 8'h55) begin
      tests_failed++;
      $display("FAIL glitch_next_data got=%h exp=55", data_bits_rx);
    end
  endtask

  task automatic test_break();
    int v0;
    int f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    tick(100);
    tests_run++;
    if (ferr_cnt - f0 !== 1) begin
      tests_failed++;
      $display("FAIL break_ferr got=%0d exp=1", ferr_cnt - f0);
    end
    tests_run++;
    if (valid_cnt - v0 !== 0) begin
      tests_failed++;
      $display("FAIL break_valid got=%0d exp=0", valid_cnt - v0);
    end
    tests_run++;
    if (data_bits_rx !== 8'h55) begin
      tests_failed++;
      $display("FAIL break_data got=%h exp=55", data_bits_rx);
    end
    tests_run++;
    if (rx_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL break_busy_low got=%b exp=1", rx_busy);
    end
    idle(5);
    tests_run++;
    if (rx_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL break_busy_high got=%b exp=0", rx_busy);
    end
    tests_run++;
    if (ferr_cnt - f0 !== 1) begin
      tests_failed++;
      $display("FAIL break_ferr_total got=%0d exp=1", ferr_cnt - f0);
    end
  endtask

  task automatic test_abort();
    int v0;
    int f0;
    logic [WS-1:0] d;
    d = 8'hA5;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    tick(PW / 2);
    rstn = 1'b0;
    rx   = 1'b1;
    tick(3);
    tests_run++;
    if (data_bits_rx !== 8'h00) begin
      tests_failed++;
      $display("FAIL abort_reset_data got=%h exp=00", data_bits_rx);
    end
    tests_run++;
    if (rx_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_reset_busy got=%b exp=0", rx_busy);
    end
    rstn = 1'b1;
    idle(20);
    tests_run++;
    if (valid_cnt - v0 !== 0) begin
      tests_failed++;
      $display("FAIL abort_valid got=%0d exp=0", valid_cnt - v0);
    end
    tests_run++;
    if (ferr_cnt - f0 !== 0) begin
      tests_failed++;
      $display("FAIL abort_ferr got=%0d exp=0", ferr_cnt - f0);
    end
    send_frame(8'h5A, 1'b1);
    idle(4);
    tests_run++;
    if (valid_cnt - v0 !== 1) begin
      tests_failed++;
      $display("FAIL abort_next_pulses got=%0d exp=1", valid_cnt - v0);
    end
    tests_run++;
    if (data_bits_rx !== 8'h5A) begin
      tests_failed++;
      $display("FAIL abort_next_data got=%h exp=5a", data_bits_rx);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int v0;
    int p0;
    v0 = valid_cnt;
    p0 = perr_cnt;
    send_frame_par(8'h07, 1'b0);
    idle(4);
    tests_run++;
    if (perr_cnt - p0 !== 1) begin
      tests_failed++;
      $display("FAIL parity_bad_perr got=%0d exp=1", perr_cnt - p0);
    end
    tests_run++;
    if (valid_cnt - v0 !== 0) begin
      tests_failed++;
      $display("FAIL parity_bad_valid got=%0d exp=0", valid_cnt - v0);
    end
    tests_run++;
    if (data_bits_rx !== 8'h5A) begin
      tests_failed++;
      $display("FAIL parity_bad_data got=%h exp=5a", data_bits_rx);
    end
    send_frame_par(8'h07, 1'b1);
    idle(4);
    tests_run++;
    if (valid_cnt - v0 !== 1) begin
      tests_failed++;
      $display("FAIL parity_good_valid got=%0d exp=1", valid_cnt - v0);
    end
    tests_run++;
    if (perr_cnt - p0 !== 1) begin
      tests_failed++;
      $display("FAIL parity_good_perr got=%0d exp=1", perr_cnt - p0);
    end
    tests_run++;
    if (data_bits_rx !== 8'h07) begin
      tests_failed++;
      $display("FAIL parity_good_data got=%h exp=07", data_bits_rx);
    end
  endtask
`endif

  task automatic test_exclusive();
    tests_run++;
    if (both_cnt !== 0) begin
      tests_failed++;
      $display("FAIL strobe_overlap got=%0d exp=0", both_cnt);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    rstn = 1'b0;
    rx   = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_abort();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have a parameter WORD_SIZE, default 8, giving the data bits per frame.
REQ-002 The module SHALL have a parameter PULSE_WIDTH, default 434, giving clk cycles per bit (115200 baud at 50 MHz); legal values are 4 and above.
REQ-003 clk  input  1  single clock; all flops SHALL be on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 rx  input  1  serial line; idles high; asynchronous to clk.
REQ-006 data_bits_rx  output  WORD_SIZE  last good received word; LSB is the first bit received.
REQ-007 rx_valid  output  1  one-cycle pulse when data_bits_rx is updated.
REQ-008 frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-009 rx_busy  output  1  high while in any state other than IDLE.

Function
REQ-010 rx SHALL pass through a two-flop synchronizer; all logic SHALL use only the synchronized value rx_s.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP, BREAK (plus PARITY when configured).
REQ-012 IDLE->START SHALL occur on the first cycle rx_s==0; the bit counter SHALL clear to 0.
REQ-013 START SHALL sample rx_s when the cycle counter reaches PULSE_WIDTH/2-1 (integer division).
  - If rx_s==1: false start; the FSM SHALL return to IDLE with no output pulse.
  - Otherwise the FSM SHALL go to DATA with the counter cleared.
REQ-014 DATA SHALL sample rx_s every PULSE_WIDTH cycles (counter 0..PULSE_WIDTH-1, sample at terminal count) into a shift register, LSB first. After WORD_SIZE samples it SHALL go to STOP (or PARITY).
REQ-015 STOP SHALL sample at terminal count.
  - If rx_s==1: the next cycle data_bits_rx SHALL take the shift register and rx_valid SHALL be 1 for exactly one cycle; the FSM SHALL go to IDLE.
  - If rx_s==0: frame_err SHALL pulse for one cycle, data_bits_rx SHALL be unchanged, and the FSM SHALL go to BREAK.
REQ-016 BREAK SHALL hold until rx_s==1, then go to IDLE; a held-low line SHALL produce exactly one frame_err.
REQ-017 rx_valid latency SHALL be 3 + PULSE_WIDTH/2 + (WORD_SIZE+1)*PULSE_WIDTH cycles after the first clk edge sampling rx low (+PULSE_WIDTH with parity).
REQ-018 A new start bit arriving in the cycle after STOP SHALL be accepted; back-to-back frames SHALL lose no data.
REQ-019 rx_valid and frame_err SHALL never be asserted in the same cycle.
REQ-020 data_bits_rx SHALL hold its value between rx_valid pulses.

Reset
REQ-021 On rstn low: state IDLE, counters 0, both synchronizer flops 1, data_bits_rx 0, rx_valid 0, frame_err 0, rx_busy 0.
REQ-022 Reset asserted mid-frame SHALL abort the frame without any pulse; after release, reception SHALL restart only on a new falling edge of rx_s.

Configuration
REQ-023 Macro UART_RX_PARITY_EN defined:
  - PARITY state between DATA and STOP samples one even-parity bit.
  - Added output parity_err (1 bit, reset 0) pulses in the cycle where rx_valid would have pulsed if parity mismatches; in that case rx_valid and the data update SHALL be suppressed.
  - Stop-bit-low frames SHALL report frame_err only.
REQ-024 Macro UART_RX_PARITY_EN undefined: no PARITY state, no parity_err port, and frame length = WORD_SIZE+2 bits.

Verification (bench PULSE_WIDTH=16, WORD_SIZE=8)
REQ-025 Drive frame 0xAB (start, 1,1,0,1,0,1,0,1, stop) -> data_bits_rx=0xAB, one rx_valid pulse at latency 3+8+144=155 cycles.
REQ-026 Drive 0x00 then 0xFF back-to-back with no idle gap -> two rx_valid pulses, values 0x00 then 0xFF.
REQ-027 Drive a 5-cycle low glitch on idle rx -> no rx_valid or frame_err pulse; FSM returns to IDLE; a following 0x55 frame is received correctly.
REQ-028 Drive 0x3C with stop bit low, then hold rx low for 100 cycles -> exactly one frame_err pulse, data_bits_rx keeps its previous value, IDLE only after rx returns high.
REQ-029 Assert rstn low during bit 4 of 0xA5, release, then send 0x5A -> no pulse for the aborted frame; data_bits_rx=0x5A.
REQ-030 With UART_RX_PARITY_EN defined, drive 0x07 with parity bit 0 (wrong) -> one parity_err pulse, no rx_valid; with parity bit 1 -> rx_valid pulse with 0x07.
